fp_add_pipe: RTL and testbench
==============================

// Module: fp_add_pipe
// PURPOSE
//  Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor.
//  Successor to the combinational FP16 adder in the arithmetic datapath: generic width,
//  3-stage pipeline, valid/ready handshake, add/sub select, round-to-nearest-even,
//  full subnormal/Inf/NaN handling and exception flags. Feeds the MAC/accumulate path.
// PARAMETERS
//  EXP_W   5   exponent field width (bias = 2**(EXP_W-1)-1)
//  MAN_W   10  stored fraction width; FP_W = 1+EXP_W+MAN_W (defaults give FP16)
//  TAG_W   4   sideband tag carried unmodified alongside each operation
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands/op/tag valid this cycle
//  in_ready   out  1      block accepts input when in_valid & in_ready
//  in_a       in   FP_W   operand A
//  in_b       in   FP_W   operand B
//  in_sub     in   1      1: A-B (B sign inverted before compute); 0: A+B
//  in_tag     in   TAG_W  sideband tag
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result when out_valid & out_ready
//  out_res    out  FP_W   result
//  out_tag    out  TAG_W  tag of the op that produced out_res
//  out_ovf    out  1      overflow: finite operands, rounded result exceeds max finite
//  out_inv    out  1      invalid: NaN operand, or Inf + (-Inf) effective subtraction
//  out_inx    out  1      inexact: rounded result != exact sum (also set on overflow)
// BEHAVIOUR
//  Reset: all stage valids, out_valid, out_res, out_tag, flags = 0, asynchronously.
//  Pipeline: S1 unpack/swap by magnitude/align (guard, round, sticky); S2 add/sub of
//   MAN_W+4-bit significands + leading-zero count; S3 normalise, RNE round, pack, flags.
//  Latency: exactly 3 cycles from accept to out_valid when never stalled; 1 op/cycle.
//  Stall: adv = ~out_valid | out_ready; in_ready = adv (combinational). When adv=0 all
//   stages hold, including bubbles (no bubble collapse). out_* stable while
//   out_valid & ~out_ready. Accept with in_valid & adv; else a bubble enters S1.
//  Alignment: smaller operand shifted right by exp diff; shifts >= MAN_W+3 reduce it to
//   sticky only. Subnormals use exponent 1 with hidden bit 0 (as predecessor).
//  Normalise: carry-out -> shift right 1, exp+1 (sticky keeps dropped bit); else left
//   shift by lzc, limited so exp never goes below 1 (result becomes subnormal).
//  Rounding: RNE on guard/round/sticky; mantissa round carry increments exponent.
//  Specials (priority order):
//   any NaN in -> canonical qNaN {0, all-1 exp, 1 followed by zeros}, inv=1, inx=0
//   +Inf + -Inf (effective sub) -> canonical qNaN, inv=1
//   one/two same-sign Inf -> that Inf, no flags
//   exact zero from opposite signs -> +0; (-0)+(-0) -> -0
//   overflow (exp reaches all-1s) -> signed Inf, ovf=1, inx=1
//  Flags are per-result and travel with it; tag travels unchanged.
//  Reset mid-operation: all in-flight ops discarded, nothing emerges after reset.
// TESTING
//  (FP16 defaults.) Arithmetic cases use out_ready=1; specials cases as listed.
//  0x3C00 + 0x3C00 -> 0x4000 after 3 cycles, flags 0; 0x4200 sub 0x3C00 -> 0x4000
//  0x3C00 + 0x1000 (tie) -> 0x3C00 inx=1; 0x3C00 + 0x1001 -> 0x3C01 inx=1
//  0x0001 + 0x0001 -> 0x0002; 0x0400 sub 0x0001 -> 0x03FF; 0x3C00 sub 0x3C00 -> 0x0000
//  0x7BFF + 0x7BFF -> 0x7C00 ovf=1 inx=1; 0x7C00 + 0xFC00 -> 0x7E00 inv=1;
//   0xFE00 + 0x3C00 -> 0x7E00 inv=1; 0x7C00 + 0x3C00 -> 0x7C00 no flags
//  Stream 8 ops tags 0..7, out_ready toggled random/held low 5 cycles -> in_ready low
//   while stalled, results in order, none lost/duplicated, out_* stable during stall
//  Assert rst with 3 ops in flight -> out_valid=0 immediately; no stale result after release

Source files
------------

// File: rtl/fp_add_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor with valid/ready handshake,
// round-to-nearest-even, subnormal/Inf/NaN handling and per-result exception flags.
module fp_add_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4,
    localparam int FP_W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_a,
    input  logic [FP_W-1:0]  in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             out_inv,
    output logic             out_inx
);
    localparam int SW  = MAN_W + 4;
    localparam int LZW = $clog2(SW + 1);
    localparam int EW1 = EXP_W + 1;
    localparam logic [FP_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ---------------- S1: unpack, order by magnitude, align ----------------
    logic             sa, sb, nan_a, nan_b, inf_a, inf_b, a_big;
    logic [EXP_W-1:0] xa, xb, ea, eb, l_exp, s_exp, d;
    logic [MAN_W:0]   ma, mb, l_sig, s_sig;
    logic             l_sgn, s_sgn;
    logic [2*SW-1:0]  sh_full;
    logic [SW-1:0]    al_small;
    logic             spc, spc_inv;
    logic [FP_W-1:0]  spc_res;

    always_comb begin
        sa    = in_a[FP_W-1];
        sb    = in_b[FP_W-1] ^ in_sub;
        xa    = in_a[FP_W-2:MAN_W];
        xb    = in_b[FP_W-2:MAN_W];
        ea    = (xa == '0) ? EXP_W'(1) : xa;
        eb    = (xb == '0) ? EXP_W'(1) : xb;
        ma    = {xa != '0, in_a[MAN_W-1:0]};
        mb    = {xb != '0, in_b[MAN_W-1:0]};
        nan_a = (xa == '1) && (in_a[MAN_W-1:0] != '0);
        nan_b = (xb == '1) && (in_b[MAN_W-1:0] != '0);
        inf_a = (xa == '1) && (in_a[MAN_W-1:0] == '0);
        inf_b = (xb == '1) && (in_b[MAN_W-1:0] == '0);
        a_big = {ea, ma} >= {eb, mb};
        if (a_big) begin
            l_sgn = sa; l_exp = ea; l_sig = ma;
            s_sgn = sb; s_exp = eb; s_sig = mb;
        end else begin
            l_sgn = sb; l_exp = eb; l_sig = mb;
            s_sgn = sa; s_exp = ea; s_sig = ma;
        end
        d = l_exp - s_exp;
        // Shift into a double-width window so every dropped bit folds into sticky.
        sh_full = {s_sig, 3'b000, {SW{1'b0}}} >> d;
        if (32'(d) >= 32'(MAN_W + 3))
            al_small = {{(SW-1){1'b0}}, |s_sig};
        else
            al_small = sh_full[2*SW-1:SW] | {{(SW-1){1'b0}}, |sh_full[SW-1:0]};

        spc     = 1'b1;
        spc_inv = 1'b0;
        spc_res = QNAN;
        if (nan_a | nan_b)
            spc_inv = 1'b1;
        else if (inf_a & inf_b & (sa != sb))
            spc_inv = 1'b1;
        else if (inf_a)
            spc_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (inf_b)
            spc_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            spc = 1'b0;
    end

    logic             s1_valid, s1_sgn, s1_sub, s1_spc, s1_inv;
    logic [EXP_W-1:0] s1_exp;
    logic [SW-1:0]    s1_big, s1_small;
    logic [FP_W-1:0]  s1_spc_res;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sgn     <= 1'b0;
            s1_sub     <= 1'b0;
            s1_spc     <= 1'b0;
            s1_inv     <= 1'b0;
            s1_exp     <= '0;
            s1_big     <= '0;
            s1_small   <= '0;
            s1_spc_res <= '0;
            s1_tag     <= '0;
        end else if (adv) begin
            s1_valid   <= in_valid;
            s1_sgn     <= l_sgn;
            s1_sub     <= l_sgn ^ s_sgn;
            s1_spc     <= spc;
            s1_inv     <= spc_inv;
            s1_exp     <= l_exp;
            s1_big     <= {l_sig, 3'b000};
            s1_small   <= al_small;
            s1_spc_res <= spc_res;
            s1_tag     <= in_tag;
        end
    end

    // ---------------- S2: significand add/sub, leading-zero count ----------------
    logic [SW:0]    sum;
    logic [LZW-1:0] lzc;
    logic           z_sgn;

    always_comb begin
        sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                     : ({1'b0, s1_big} + {1'b0, s1_small});
        lzc = LZW'(SW);
        for (int unsigned i = 0; i < SW; i++)
            if (sum[i]) lzc = LZW'(SW - 1 - i);
        // Exact cancellation gives +0; only (-0)+(-0) keeps the negative sign.
        z_sgn = (sum == '0) ? (s1_sgn & ~s1_sub) : s1_sgn;
    end

    logic             s2_valid, s2_sgn, s2_spc, s2_inv;
    logic [EXP_W-1:0] s2_exp;
    logic [SW:0]      s2_sum;
    logic [LZW-1:0]   s2_lzc;
    logic [FP_W-1:0]  s2_spc_res;
    logic [TAG_W-1:0] s2_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_sgn     <= 1'b0;
            s2_spc     <= 1'b0;
            s2_inv     <= 1'b0;
            s2_exp     <= '0;
            s2_sum     <= '0;
            s2_lzc     <= '0;
            s2_spc_res <= '0;
            s2_tag     <= '0;
        end else if (adv) begin
            s2_valid   <= s1_valid;
            s2_sgn     <= z_sgn;
            s2_spc     <= s1_spc;
            s2_inv     <= s1_inv;
            s2_exp     <= s1_exp;
            s2_sum     <= sum;
            s2_lzc     <= lzc;
            s2_spc_res <= s1_spc_res;
            s2_tag     <= s1_tag;
        end
    end

    // ---------------- S3: normalise, round, pack, flags ----------------
    logic [SW-1:0]    m;
    logic [EW1-1:0]   e, e_fld;
    logic [EXP_W-1:0] max_sh;
    int unsigned      sh;
    logic             up, inx, ovf;
    logic [MAN_W+1:0] rnd;
    logic [FP_W-1:0]  res;
    logic [2:0]       flg;

    always_comb begin
        max_sh = s2_exp - EXP_W'(1);
        sh     = 0;
        if (s2_sum[SW]) begin
            m = s2_sum[SW:1] | {{(SW-1){1'b0}}, s2_sum[0]};
            e = {1'b0, s2_exp} + EW1'(1);
        end else begin
            // Left shift stops at exponent 1; anything left unnormalised is subnormal.
            sh = (32'(s2_lzc) < 32'(max_sh)) ? 32'(s2_lzc) : 32'(max_sh);
            m  = s2_sum[SW-1:0] << sh;
            e  = {1'b0, s2_exp} - EW1'(sh);
        end
        up    = m[2] & (m[1] | m[0] | m[3]);
        inx   = |m[2:0];
        rnd   = {1'b0, m[SW-1:3]} + (MAN_W+2)'(up);
        e_fld = (rnd[MAN_W+1] | rnd[MAN_W]) ? e + EW1'(rnd[MAN_W+1]) : '0;
        ovf   = e_fld >= EW1'({EXP_W{1'b1}});
        if (s2_spc) begin
            res = s2_spc_res;
            flg = {1'b0, s2_inv, 1'b0};
        end else if (ovf) begin
            res = {s2_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg = 3'b101;
        end else begin
            res = {s2_sgn, e_fld[EXP_W-1:0], rnd[MAN_W-1:0]};
            flg = {2'b00, inx};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_tag   <= '0;
            out_ovf   <= 1'b0;
            out_inv   <= 1'b0;
            out_inx   <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_res   <= res;
            out_tag   <= s2_tag;
            {out_ovf, out_inv, out_inx} <= flg;
        end
    end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Table-driven, scoreboarded bench for fp_add_pipe at FP16 defaults: latency,
// arithmetic/special vectors, back-pressure streaming and mid-flight reset.
module tb_fp_add_pipe;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int TAG_W = 4;
    localparam int FP_W  = 16;
    localparam int NV    = 18;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, in_sub;
    logic             out_valid, out_ready, out_ovf, out_inv, out_inx;
    logic [FP_W-1:0]  in_a, in_b, out_res;
    logic [TAG_W-1:0] in_tag, out_tag;

    always #5 clk = ~clk;

    fp_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag),
        .out_ovf(out_ovf), .out_inv(out_inv), .out_inx(out_inx)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] res;
        logic [2:0]  flg;   // {ovf, inv, inx}
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  tag;
        logic [2:0]  flg;
    } exp_t;

    vec_t vecs[NV];
    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_recv  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: tag %0d res %h with empty scoreboard", out_tag, out_res);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("res tag%0d", mon_e.tag), 32'(out_res), 32'(mon_e.res));
                check($sformatf("tag tag%0d", mon_e.tag), 32'(out_tag), 32'(mon_e.tag));
                check($sformatf("flags tag%0d", mon_e.tag), 32'({out_ovf, out_inv, out_inx}), 32'(mon_e.flg));
                n_recv++;
            end
        end
    end

    task automatic send(input int idx, input logic [3:0] tag);
        int unsigned n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_a     = vecs[idx].a;
        in_b     = vecs[idx].b;
        in_sub   = vecs[idx].sub;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout tag%0d: in_ready 0, expected 1", tag);
        end else begin
            e.res = vecs[idx].res;
            e.tag = tag;
            e.flg = vecs[idx].flg;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, 32'(sb.size()), 32'(0));
    endtask

    task automatic stall_proc(input int target);
        int unsigned n = 0;
        logic [15:0] hr;
        logic [3:0]  ht;
        logic [2:0]  hf;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_out_valid", 32'(out_valid), 32'(1));
        hr = out_res;
        ht = out_tag;
        hf = {out_ovf, out_inv, out_inx};
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall_in_ready", 32'(in_ready), 32'(0));
            check("stall_out_valid_held", 32'(out_valid), 32'(1));
            check("stall_res_stable", 32'(out_res), 32'(hr));
            check("stall_tag_stable", 32'(out_tag), 32'(ht));
            check("stall_flags_stable", 32'({out_ovf, out_inv, out_inx}), 32'(hf));
        end
        n = 0;
        while (n_recv < target && n < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   recv0;
        logic seen;
        vecs[0]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000};
        vecs[1]  = '{16'h4200, 16'h3C00, 1'b1, 16'h4000, 3'b000};
        vecs[2]  = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b001};
        vecs[3]  = '{16'h3C00, 16'h1001, 1'b0, 16'h3C01, 3'b001};
        vecs[4]  = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 3'b000};
        vecs[5]  = '{16'h0400, 16'h0001, 1'b1, 16'h03FF, 3'b000};
        vecs[6]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000};
        vecs[7]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b101};
        vecs[8]  = '{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b010};
        vecs[9]  = '{16'hFE00, 16'h3C00, 1'b0, 16'h7E00, 3'b010};
        vecs[10] = '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 3'b000};
        vecs[11] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000};
        vecs[12] = '{16'h0000, 16'h8000, 1'b0, 16'h0000, 3'b000};
        vecs[13] = '{16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 3'b000};
        vecs[14] = '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 3'b010};
        vecs[15] = '{16'hC000, 16'h3C00, 1'b0, 16'hBC00, 3'b000};
        vecs[16] = '{16'h3800, 16'h3400, 1'b0, 16'h3A00, 3'b000};
        vecs[17] = '{16'h3BFF, 16'h0C00, 1'b0, 16'h3C00, 3'b001};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_out_res", 32'(out_res), 32'(0));
        check("reset_out_tag", 32'(out_tag), 32'(0));
        check("reset_flags", 32'({out_ovf, out_inv, out_inx}), 32'(0));
        check("reset_in_ready", 32'(in_ready), 32'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency: accepted at edge N, visible after edge N+2.
        send(0, 4'd0);
        check("lat_edge1", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        check("lat_edge2", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        check("lat_edge3", 32'(out_valid), 32'(1));
        drain("latency");

        for (int i = 0; i < NV; i++) send(i, 4'(i));
        drain("table");

        recv0     = n_recv;
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 8; i++) send(i, 4'(i));
            stall_proc(recv0 + 8);
        join
        out_ready = 1'b1;
        drain("stream");
        check("stream_count", 32'(n_recv - recv0), 32'(8));

        for (int i = 0; i < 3; i++) send(i + 15, 4'(i + 9));
        rst = 1'b1;
        #1;
        check("rst_async_out_valid", 32'(out_valid), 32'(0));
        check("rst_async_out_res", 32'(out_res), 32'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("rst_no_stale", 32'(seen), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
